// File: rtl/id_forward_scoreboard.sv
// ID-stage forwarding/interlock: a shift-register scoreboard of in-flight register
// writes that forwards the youngest ready value to each ID read port or stalls ID.
module id_forward_scoreboard #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NUM_READ  = 2,
    parameter int DEPTH     = 3,
    parameter int LOAD_SLOT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold_i,
    input  logic                   id_valid_i,
    input  logic                   id_flush_i,
    input  logic [NUM_READ-1:0]    id_use_mask_i,
    input  logic [NUM_READ*AW-1:0] id_raddr_i,
    input  logic [NUM_READ*DW-1:0] id_rfdata_i,
    input  logic                   id_regwrite_i,
    input  logic [AW-1:0]          id_wreg_i,
    input  logic [1:0]             id_regsrc_i,
    input  logic [DW-1:0]          id_pc_i,
    input  logic [DW-1:0]          ex_alu_result_i,
    input  logic [DW-1:0]          mem_rdata_i,
    output logic [NUM_READ*DW-1:0] id_fwd_data_o,
    output logic [NUM_READ-1:0]    id_fwd_hit_o,
    output logic                   id_stall_o,
    output logic [15:0]            stall_cnt_o
);

    localparam logic [1:0] REGSRC_ALU     = 2'b00;
    localparam logic [1:0] REGSRC_DMEM    = 2'b01;
    localparam logic [1:0] REGSRC_PCPLUS4 = 2'b10;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wreg;
        logic [1:0]    src;
        logic          rdy;
        logic [DW-1:0] val;
    } slot_t;

    slot_t               slot_q [DEPTH];
    slot_t               slot_d [DEPTH];
    logic [15:0]         stall_cnt_q;
    logic [15:0]         stall_cnt_d;
    logic [NUM_READ-1:0] hazard;
    logic [AW-1:0]       rd;
    logic                found;
    logic                insert;

    // Youngest (lowest-index) match decides; older entries are never consulted.
    always_comb begin
        id_fwd_data_o = id_rfdata_i;
        id_fwd_hit_o  = '0;
        hazard        = '0;
        rd            = '0;
        found         = 1'b0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd    = id_raddr_i[p*AW +: AW];
            found = 1'b0;
            if (id_use_mask_i[p] && rd != '0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!found && slot_q[k].valid && slot_q[k].wreg == rd) begin
                        found = 1'b1;
                        if (slot_q[k].rdy) begin
                            id_fwd_data_o[p*DW +: DW] = slot_q[k].val;
                            id_fwd_hit_o[p]           = 1'b1;
                        end else begin
                            hazard[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign id_stall_o  = id_valid_i & ~id_flush_i & (|hazard);
    assign stall_cnt_o = stall_cnt_q;
    assign insert      = id_valid_i & ~id_flush_i & ~id_stall_o & id_regwrite_i
                         & (id_wreg_i != '0);

    always_comb begin
        for (int k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k];
        stall_cnt_d = stall_cnt_q;
        if (!hold_i) begin
            slot_d[0]       = '0;
            slot_d[0].valid = insert;
            slot_d[0].wreg  = id_wreg_i;
            slot_d[0].src   = id_regsrc_i;
            if (id_regsrc_i == REGSRC_PCPLUS4) begin
                slot_d[0].rdy = 1'b1;
                slot_d[0].val = id_pc_i + DW'(4);
            end
            // Results are captured as the producer moves past the stage that makes them.
            for (int k = 1; k < DEPTH; k++) begin
                slot_d[k] = slot_q[k-1];
                if (k == 1 && slot_q[k-1].src == REGSRC_ALU) begin
                    slot_d[k].rdy = 1'b1;
                    slot_d[k].val = ex_alu_result_i;
                end
                if (k == LOAD_SLOT && slot_q[k-1].src == REGSRC_DMEM) begin
                    slot_d[k].rdy = 1'b1;
                    slot_d[k].val = mem_rdata_i;
                end
            end
            if (id_stall_o && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// Directed bench for id_forward_scoreboard: default instance for forwarding/stall
// behaviour, deep-load instance for counter saturation.
module tb_id_forward_scoreboard;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_DMEM = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        id_valid;
    logic        id_flush;
    logic [1:0]  use_mask;
    logic [9:0]  raddr;
    logic [63:0] rfdata;
    logic        regwrite;
    logic [4:0]  wreg;
    logic [1:0]  regsrc;
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] mem_rd;
    logic [63:0] fwd;
    logic [1:0]  hit;
    logic        stall;
    logic [15:0] cnt;

    logic [63:0] s_fwd;
    logic [1:0]  s_hit;
    logic        s_stall;
    logic [15:0] s_cnt;
    logic        s_valid;
    logic [1:0]  s_mask;
    logic [9:0]  s_raddr;
    logic        s_regwrite;

    int n_total = 0;
    int n_bad   = 0;

    id_forward_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold), .id_valid_i(id_valid),
        .id_flush_i(id_flush), .id_use_mask_i(use_mask), .id_raddr_i(raddr),
        .id_rfdata_i(rfdata), .id_regwrite_i(regwrite), .id_wreg_i(wreg),
        .id_regsrc_i(regsrc), .id_pc_i(pc), .ex_alu_result_i(alu_res),
        .mem_rdata_i(mem_rd), .id_fwd_data_o(fwd), .id_fwd_hit_o(hit),
        .id_stall_o(stall), .stall_cnt_o(cnt)
    );

    id_forward_scoreboard #(.DEPTH(64), .LOAD_SLOT(63)) dut_sat (
        .clk(clk), .rst_n(rst_n), .hold_i(1'b0), .id_valid_i(s_valid),
        .id_flush_i(1'b0), .id_use_mask_i(s_mask), .id_raddr_i(s_raddr),
        .id_rfdata_i(rfdata), .id_regwrite_i(s_regwrite), .id_wreg_i(5'd4),
        .id_regsrc_i(SRC_DMEM), .id_pc_i(32'h0), .ex_alu_result_i(32'h0),
        .mem_rdata_i(32'h0000_1234), .id_fwd_data_o(s_fwd), .id_fwd_hit_o(s_hit),
        .id_stall_o(s_stall), .stall_cnt_o(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic rw, input logic [4:0] wr,
                          input logic [1:0] src, input logic [1:0] mask,
                          input logic [4:0] r0, input logic [4:0] r1);
        id_valid = v;
        regwrite = rw;
        wreg     = wr;
        regsrc   = src;
        use_mask = mask;
        raddr    = {r1, r0};
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; id_flush = 1'b0; pc = 32'h0;
        alu_res = 32'h0; mem_rd = 32'h0;
        rfdata = {32'h0000_2222, 32'h0000_1111};
        s_valid = 1'b0; s_mask = 2'b00; s_raddr = '0; s_regwrite = 1'b0;
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b01, 5'd8, 5'd9);
        check("rst_fwd0", fwd[31:0], 64'h1111);
        check("rst_stall", stall, 0);
        check("rst_cnt", cnt, 0);
        check("rst_hit", hit, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // jal r31 then jr r31
        pc = 32'h0040_0010;
        set_id(1'b1, 1'b1, 5'd31, SRC_PC4, 2'b00, 5'd0, 5'd0);
        tick();
        pc = 32'h0;
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b01, 5'd31, 5'd0);
        check("pc4_fwd0", fwd[31:0], 64'h0040_0014);
        check("pc4_hit0", hit[0], 1);
        check("pc4_stall", stall, 0);

        // addu r8; beq r8,r9
        set_id(1'b1, 1'b1, 5'd8, SRC_ALU, 2'b00, 5'd0, 5'd0);
        tick();
        alu_res = 32'h5;
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b11, 5'd8, 5'd9);
        check("alu_stall", stall, 1);
        check("alu_hit_during", hit, 0);
        tick();
        check("alu_stall_after", stall, 0);
        check("alu_fwd0", fwd[31:0], 64'h5);
        check("alu_hit", hit, 2'b01);
        check("alu_fwd1_rf", fwd[63:32], 64'h2222);
        check("alu_cnt", cnt, 1);

        // two addu r8 back-to-back; the younger one wins
        set_id(1'b1, 1'b1, 5'd8, SRC_ALU, 2'b00, 5'd0, 5'd0);
        tick();
        alu_res = 32'h5;
        tick();
        alu_res = 32'h7;
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b01, 5'd8, 5'd0);
        check("prio_stall", stall, 1);
        check("prio_hit_during", hit, 0);
        tick();
        check("prio_fwd0", fwd[31:0], 64'h7);
        check("prio_stall_after", stall, 0);
        check("prio_cnt", cnt, 2);

        // lw r4; bne r4 with a hold in the middle of the stall
        set_id(1'b1, 1'b1, 5'd4, SRC_DMEM, 2'b00, 5'd0, 5'd0);
        tick();
        mem_rd = 32'hDEAD_BEEF;
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b01, 5'd4, 5'd0);
        check("ld_stall1", stall, 1);
        tick();
        check("ld_stall2", stall, 1);
        check("ld_cnt1", cnt, 3);
        hold = 1'b1;
        tick();
        check("ld_hold_stall", stall, 1);
        check("ld_hold_cnt", cnt, 3);
        hold = 1'b0;
        tick();
        check("ld_stall_after", stall, 0);
        check("ld_fwd0", fwd[31:0], 64'hDEAD_BEEF);
        check("ld_hit0", hit[0], 1);
        check("ld_cnt2", cnt, 4);

        // r0 write, r0 read
        set_id(1'b1, 1'b1, 5'd0, SRC_DMEM, 2'b00, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b01, 5'd0, 5'd0);
        check("r0_fwd0", fwd[31:0], 64'h1111);
        check("r0_stall", stall, 0);
        check("r0_hit", hit, 0);

        // pending r5 seen through unmasked ports only
        set_id(1'b1, 1'b1, 5'd5, SRC_DMEM, 2'b00, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b00, 5'd5, 5'd5);
        check("mask_stall", stall, 0);
        check("mask_fwd", fwd, 64'h0000_2222_0000_1111);
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b10, 5'd5, 5'd5);
        check("mask1_stall", stall, 1);

        // flushed hazarding instruction writing r6 must leave a bubble
        id_flush = 1'b1;
        set_id(1'b1, 1'b1, 5'd6, SRC_ALU, 2'b10, 5'd0, 5'd5);
        check("flush_stall", stall, 0);
        tick();
        id_flush = 1'b0;
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b01, 5'd6, 5'd0);
        check("flush_bubble_stall", stall, 0);
        check("flush_bubble_hit", hit, 0);
        check("flush_bubble_fwd0", fwd[31:0], 64'h1111);

        // reset while stalled on pending r5
        set_id(1'b1, 1'b0, 5'd0, SRC_ALU, 2'b01, 5'd5, 5'd0);
        check("prerst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("rst_stall_clr", stall, 0);
        check("rst_hit_clr", hit, 0);
        check("rst_cnt_clr", cnt, 0);
        tick();
        rst_n = 1'b1;
        set_id(1'b0, 1'b0, 5'd0, SRC_ALU, 2'b00, 5'd0, 5'd0);
        tick();

        // saturation: each load-use period is 64 cycles with 63 stalls
        s_valid = 1'b1; s_regwrite = 1'b1; s_mask = 2'b01; s_raddr = {5'd0, 5'd4};
        #1;
        repeat (1 + 64 * 1040) tick();
        check("sat_pre", s_cnt, 16'd65520);
        repeat (128) tick();
        check("sat_hold", s_cnt, 16'hFFFF);
        repeat (64) tick();
        check("sat_stay", s_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/id_forward_scoreboard.md
# id_forward_scoreboard

Parametrised ID-stage forwarding and interlock unit for the pipelined core. It replaces the fixed two-port, EX/MEM-only ID bypass with a shift-register scoreboard of in-flight register writes. The scoreboard captures each producer's result as the result becomes available, forwards the youngest ready value to any number of ID read ports, and raises a stall when a needed value is still pending. It sits beside the register file in ID and feeds branch compare and register-jump target logic.

## Interface
- DW, 32, data width
- AW, 5, register address width
- NUM_READ, 2, ID read ports
- DEPTH, 3, tracked slots after ID (slot 0 = EX … DEPTH-1 = WB); DEPTH ≥ 3
- LOAD_SLOT, 2, slot from which load data is valid; 2 ≤ LOAD_SLOT ≤ DEPTH-1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  global pipeline freeze
- id_valid  in  1  ID holds a real instruction
- id_flush  in  1  ID instruction is squashed this cycle
- id_use_mask  in  NUM_READ  port p is needed at ID (branch/jump-reg)
- id_raddr  in  NUM_READ*AW  packed read addresses, port 0 in LSBs
- id_rfdata  in  NUM_READ*DW  packed register-file read data
- id_regwrite  in  1  ID instruction writes a register
- id_wreg  in  AW  destination register
- id_regsrc  in  2  REGSRC_ALU / REGSRC_DMEM / REGSRC_PCPLUS4 (ctrl_encode_def.v)
- id_pc  in  DW  PC of ID instruction
- ex_alu_result  in  DW  ALU result of the slot-0 instruction
- mem_rdata  in  DW  load data of the slot LOAD_SLOT-1 instruction
- id_fwd_data  out  NUM_READ*DW  corrected operands
- id_fwd_hit  out  NUM_READ  port p was satisfied from the scoreboard
- id_stall  out  1  hold ID and PC; insert bubble
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Each slot entry holds: valid, wreg, src, ready, value.
- Insertion: when !hold, slot 0 loads the ID instruction if id_valid & !id_flush & !id_stall & id_regwrite & id_wreg≠0. Otherwise slot 0 loads a bubble (valid=0).
- Insertion by source:
  - PCPLUS4 entries insert with ready=1 and value=id_pc+4 (mod 2^DW).
  - ALU and DMEM entries insert with ready=0.
- Shift: when !hold, slot k+1 ← slot k for every slot; slot DEPTH-1 retires.
- Capture happens during the shift:
  - An ALU entry leaving slot 0 takes value=ex_alu_result and ready=1.
  - A DMEM entry leaving slot LOAD_SLOT-1 takes value=mem_rdata and ready=1.
- Lookup, per port p (combinational):
  - If use_mask[p]=0 or raddr=0, output id_rfdata and no hazard.
  - Otherwise, the lowest-index valid slot with wreg=raddr is the match. If it is ready, output its value and set hit[p]=1. If it is not ready, the port has a hazard.
  - If there is no match, output id_rfdata.
- Only the youngest match is consulted; an older ready entry never masks a younger pending one.
- id_stall = id_valid & !id_flush & (any port hazard).
- stall_cnt increments when id_stall & !hold and saturates at 16'hFFFF.
- hold=1:
  - No shift, no capture, no insertion; stall_cnt unchanged.
  - Outputs still computed from frozen state.
- Reset (async, rst_n=0):
  - All slots go invalid and stall_cnt=0.
  - Therefore id_stall=0, id_fwd_hit=0, and id_fwd_data=id_rfdata immediately.
  - Reset during a stall discards all pending entries.

## Timing
- Forwarding, stall and hit are purely combinational from inputs and state: zero-cycle latency.
- State changes only at the rising clk edge (except async reset).
- ALU producer at distance 1 (in slot 0) causes 1 stall cycle; usable from the next edge.
- Load producer in slot 0 causes LOAD_SLOT stall cycles when it directly precedes the consumer.
- PCPLUS4 producer: never stalls.
- Entry in slot DEPTH-1 is forwarded in the same cycle as its RF write (covers RF without write-through).
- Simultaneous flush and hazard: flush wins; no stall and a bubble is inserted.
- Simultaneous hold and hazard: id_stall stays high and the counter does not advance.

## Test plan
- Reset: rst_n=0 with id_rfdata port0=32'h1111 → fwd0=32'h1111, id_stall=0, stall_cnt=0, without a clock edge.
- PCPLUS4 chain:
  - Stimulus: jal writes r31 at id_pc=32'h0040_0010; next cycle jr r31 uses port 0.
  - Required: fwd0=32'h0040_0014, hit0=1, no stall.
- ALU hazard:
  - Stimulus: addu r8 followed by beq r8,r9, with ex_alu_result=32'h5.
  - Required: 1 stall cycle, then fwd0=32'h5 and stall_cnt=1.
  - A second addu r8 inserted behind it with result 32'h7 takes priority: fwd0=32'h7.
- Load hazard:
  - Stimulus: lw r4 with LOAD_SLOT=2 and mem_rdata=32'hDEAD_BEEF; next bne r4.
  - Required: 2 stall cycles, then fwd0=32'hDEAD_BEEF.
  - hold=1 during the stall keeps id_stall=1 and stall_cnt frozen.
- Masking and boundaries:
  - Writes to r0 are never tracked; a port with use_mask=0 matching a pending r5 passes rfdata with no stall.
  - id_flush during a hazard → id_stall=0 and slot 0 becomes a bubble.
- Saturation: preload a stall condition for 65,540 cycles → stall_cnt holds 16'hFFFF.
